// File: rtl/data_frame_builder.sv
// data_frame_builder: buffers an 8-bit valid/ready stream in a FIFO and emits header+payload frames.
// Optional checksum byte per frame when FRAME_CKSUM_EN is defined.
module data_frame_builder #(
  parameter int FRAME_LEN = 4,
  parameter int FIFO_DEPTH = 8,
  parameter logic [3:0] HDR_TAG = 4'hA
) (
  input  logic clk,
  input  logic rst,
  input  logic valid_in,
  output logic ready_in,
  input  logic [7:0] data_in,
  output logic valid_out,
  input  logic ready_out,
  output logic [7:0] data_out,
  output logic last_out,
  output logic [7:0] frame_cnt,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int IW = $clog2(FRAME_LEN + 1);
`ifdef FRAME_CKSUM_EN
  typedef enum logic [1:0] {IDLE, PAYLOAD, CKSUM} state_t;
  logic [7:0] sum_q, sum_d;
`else
  typedef enum logic {IDLE, PAYLOAD} state_t;
`endif
  state_t state_q, state_d;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [IW-1:0] idx_q, idx_d;
  logic valid_q, valid_d, last_q, last_d;
  logic [7:0] data_q, data_d, frame_cnt_q, frame_cnt_d, hdr, rd_byte;
  logic slot_free, push, pop, idx_end;
  assign ready_in = level_q != LW'(FIFO_DEPTH);
  assign valid_out = valid_q;
  assign data_out = data_q;
  assign last_out = last_q;
  assign frame_cnt = frame_cnt_q;
  assign fifo_level = level_q;
  always_comb begin
    slot_free = !valid_q || ready_out;
    push = valid_in && ready_in;
    pop = state_q == PAYLOAD && slot_free;
    rd_byte = mem_q[rd_ptr_q];
    idx_end = idx_q == IW'(FRAME_LEN - 1);
    // header of a back-to-back frame must see the count of the frame finishing this cycle
    frame_cnt_d = frame_cnt_q + 8'(valid_q && ready_out && last_q);
    hdr = {HDR_TAG, frame_cnt_d[3:0]};
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d = level_q + LW'(push) - LW'(pop);
    state_d = state_q;
    idx_d = idx_q;
    valid_d = slot_free ? 1'b0 : valid_q;
    last_d = slot_free ? 1'b0 : last_q;
    data_d = data_q;
`ifdef FRAME_CKSUM_EN
    sum_d = sum_q;
`endif
    if (slot_free && state_q == IDLE && level_q >= LW'(FRAME_LEN)) begin
      state_d = PAYLOAD;
      valid_d = 1'b1;
      data_d = hdr;
      idx_d = '0;
`ifdef FRAME_CKSUM_EN
      sum_d = hdr;
`endif
    end else if (pop) begin
      valid_d = 1'b1;
      data_d = rd_byte;
      idx_d = idx_q + IW'(1);
`ifdef FRAME_CKSUM_EN
      sum_d = sum_q + rd_byte;
      state_d = idx_end ? CKSUM : PAYLOAD;
`else
      state_d = idx_end ? IDLE : PAYLOAD;
      last_d = idx_end;
`endif
    end
`ifdef FRAME_CKSUM_EN
    else if (slot_free && state_q == CKSUM) begin
      valid_d = 1'b1;
      data_d = ~sum_q + 8'd1;
      last_d = 1'b1;
      state_d = IDLE;
    end
`endif
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_in;
    if (rst) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q <= '0;
      idx_q <= '0;
      valid_q <= 1'b0;
      last_q <= 1'b0;
      data_q <= '0;
      frame_cnt_q <= '0;
`ifdef FRAME_CKSUM_EN
      sum_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q <= level_d;
      idx_q <= idx_d;
      valid_q <= valid_d;
      last_q <= last_d;
      data_q <= data_d;
      frame_cnt_q <= frame_cnt_d;
`ifdef FRAME_CKSUM_EN
      sum_q <= sum_d;
`endif
    end
  end
endmodule

// File: tb/tb_data_frame_builder.sv
// tb_data_frame_builder: randomized + directed scoreboard bench for data_frame_builder.
module tb_data_frame_builder;
  localparam int FL = 4;
  localparam int FD = 8;
  localparam int LW = $clog2(FD) + 1;
`ifdef FRAME_CKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, valid_in = 1'b0, ready_out = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic ready_in, valid_out, last_out;
  logic [7:0] data_out, frame_cnt;
  logic [LW-1:0] fifo_level;
  data_frame_builder #(.FRAME_LEN(FL), .FIFO_DEPTH(FD), .HDR_TAG(4'hA)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_in), .data_in(data_in),
    .valid_out(valid_out), .ready_out(ready_out), .data_out(data_out), .last_out(last_out),
    .frame_cnt(frame_cnt), .fifo_level(fifo_level)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0, xfers = 0, frames_formed = 0, fc_model = 0;
  logic [7:0] pend[$];
  logic [8:0] expq[$];
  bit hold_v = 1'b0;
  logic [8:0] hold_q, e;
  logic [7:0] s, h, b;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic timeout(input string n);
    checks++;
    errors++;
    $display("FAIL %s: bound expired, got no event expected one", n);
  endtask
  // scoreboard: frames are formed from accepted bytes; outputs are checked on every transfer
  always @(negedge clk) begin
    if (rst) begin
      pend.delete();
      expq.delete();
      frames_formed = 0;
      fc_model = 0;
      hold_v = 1'b0;
    end else begin
      chk("ready_in_vs_level", ready_in, fifo_level != LW'(FD));
      chk("level_range", fifo_level <= LW'(FD), 1);
      chk("frame_cnt", frame_cnt, fc_model[7:0]);
      if (hold_v) begin
        chk("hold_valid", valid_out, 1);
        chk("hold_byte", {last_out, data_out}, hold_q);
      end
      hold_v = valid_out && !ready_out;
      hold_q = {last_out, data_out};
      if (valid_out && ready_out) begin
        xfers++;
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out: got %0h expected no byte", {last_out, data_out});
        end else begin
          e = expq.pop_front();
          chk("out_byte", {last_out, data_out}, e);
          if (e[8]) fc_model++;
        end
      end
      if (valid_in && ready_in) begin
        pend.push_back(data_in);
        if (pend.size() == FL) begin
          h = {4'hA, 4'(frames_formed % 16)};
          s = h;
          expq.push_back({1'b0, h});
          for (int i = 0; i < FL; i++) begin
            b = pend.pop_front();
            s = s + b;
            expq.push_back({!CK && i == FL - 1, b});
          end
          if (CK) expq.push_back({1'b1, 8'(256 - int'(s))});
          frames_formed++;
        end
      end
    end
  end
  task automatic push(input logic [7:0] v);
    bit ok;
    int n;
    n = 0;
    valid_in = 1'b1;
    data_in = v;
    do begin
      @(negedge clk);
      ok = ready_in;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 1000);
    if (!ok) timeout("push");
    valid_in = 1'b0;
  endtask
  task automatic drain();
    int n;
    n = 0;
    valid_in = 1'b0;
    ready_out = 1'b1;
    while (expq.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_left", expq.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask
  initial begin
    int n, base;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", valid_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_last", last_out, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ready_in", ready_in, 1);
    rst = 1'b0;
    ready_out = 1'b1;
    for (int i = 1; i <= 4; i++) push(8'(i));
    @(posedge clk);
    #1;
    chk("hdr_latency_valid", valid_out, 1);
    chk("hdr_latency_data", data_out, 8'hA0);
    n = 0;
    while (valid_out && n < 20) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk("stream_len", n, CK ? FL + 2 : FL + 1);
    chk("frame_cnt_1", frame_cnt, 1);
    for (int i = 1; i <= 4; i++) push(8'(16 * i));
    n = 0;
    while (!(valid_out && last_out) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("f2_last_byte", data_out, CK ? 8'hBF : 8'h40);
    drain();
    ready_out = 1'b0;
    for (int i = 0; i < 8; i++) push(8'(8'h21 + i));
    chk("stall_level", fifo_level, 8);
    chk("stall_ready_in", ready_in, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("stall_valid", valid_out, 1);
    chk("stall_hdr", data_out, 8'hA2);
    chk("stall_last", last_out, 0);
    drain();
    chk("frame_cnt_4", frame_cnt, 4);
    ready_out = 1'b0;
    fork
      for (int i = 0; i < 4; i++) push(8'($urandom));
      repeat (24) begin
        @(posedge clk);
        #1;
        ready_out = ~ready_out;
      end
    join
    drain();
    chk("frame_cnt_5", frame_cnt, 5);
    base = xfers;
    for (int i = 0; i < 6; i++) push(8'($urandom));
    n = 0;
    while (xfers < base + 3 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (xfers < base + 3) timeout("mid_frame_wait");
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_valid", valid_out, 0);
    chk("midrst_level", fifo_level, 0);
    chk("midrst_frame_cnt", frame_cnt, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) push(8'($urandom));
    n = 0;
    while (!valid_out && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("midrst_next_hdr", data_out, 8'hA0);
    drain();
    for (int i = 0; i < 1500; i++) begin
      valid_in = 1'($urandom_range(0, 1));
      data_in = 8'($urandom);
      ready_out = $urandom_range(0, 3) != 0;
      @(posedge clk);
      #1;
    end
    drain();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ready_out = 1'b1;
    for (int i = 0; i < 256 * FL; i++) push(8'($urandom));
    drain();
    chk("wrap_frame_cnt", frame_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
